mem_responder: RTL and testbench

Single-clock memory slave that answers the core's instruction fetch port and data load/store port from one shared word array. It also provides a backdoor loader port so the program image can be written before, or between, runs. It sits directly outside the CPU top level: instruction and data reads are combinational to match the core's same-cycle fetch and load sampling, and writes commit on the clock edge. A small mode FSM gates CPU access during loading, and sticky error tracking flags misaligned accesses.

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_mem_array.sv | 32 +++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared mode encoding, default constants and counter widths for the
// mem_responder memory slave and its storage array.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } mode_t;

  localparam int          WORD_W            = 32;
  localparam int          ERR_COUNT_W       = 8;
  localparam int          LOAD_WORDS_W      = 16;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // A byte address is misaligned for a word access when either low bit is set.
  function automatic logic misaligned(input logic [1:0] byte_off);
    return |byte_off;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word array with one clocked write port and two combinational read ports
// (fetch and data). Contents are deliberately left unreset.
module mem_array #(
  parameter int IDX_W  = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [IDX_W-1:0]  rd_idx_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Reads see the old word until the write edge, which gives the
  // read-during-write behaviour the core relies on for self-modifying code.
  assign rd_data_a = mem[rd_idx_a];
  assign rd_data_b = mem[rd_idx_b];

endmodule

// File: rtl/mem_responder.sv
// Shared instruction/data memory slave with a backdoor loader port, a
// mode FSM that gates CPU access while loading, and misalignment tracking.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_read,
  input  logic [31:0]             instr_addr,
  output logic [31:0]             instr_out,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [31:0]             data_addr,
  input  logic [31:0]             data_in,
  output logic [31:0]             data_out,
  input  logic                    load_en,
  input  logic                    load_we,
  input  logic [31:0]             load_addr,
  input  logic [31:0]             load_data,
  input  logic                    start,
  output logic                    ready,
  output logic                    misalign_err,
  output logic [ERR_COUNT_W-1:0]  err_count,
  output logic [LOAD_WORDS_W-1:0] load_words
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  mode_t             mode;
  logic [IDX_W-1:0]  instr_idx;
  logic [IDX_W-1:0]  data_idx;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] instr_word;
  logic [WORD_W-1:0] data_word;
  logic              cpu_run;
  logic              cpu_wr;
  logic              loader_wr;
  logic              wr_en;
  logic              misalign_hit;
  logic              unused_addr_bits;

  // Upper address bits wrap away and loader writes are always word-wide.
  assign unused_addr_bits = ^{instr_addr[31:ADDR_WIDTH], data_addr[31:ADDR_WIDTH],
                              load_addr[31:ADDR_WIDTH], load_addr[1:0]};

  assign instr_idx = instr_addr[ADDR_WIDTH-1:2];
  assign data_idx  = data_addr[ADDR_WIDTH-1:2];
  assign load_idx  = load_addr[ADDR_WIDTH-1:2];

  // Gating follows the registered mode, so the access in the cycle load_en
  // rises during RUN still completes.
  assign cpu_run   = (mode == RUN);
  assign cpu_wr    = cpu_run && data_write;
  assign loader_wr = (mode == LOAD) && load_en && load_we;
  assign wr_en     = !rst && (loader_wr || cpu_wr);
  assign wr_idx    = loader_wr ? load_idx  : data_idx;
  assign wr_data   = loader_wr ? load_data : data_in;

  mem_array #(
    .IDX_W  (IDX_W),
    .DATA_W (WORD_W)
  ) u_array (
    .clk       (clk),
    .we        (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_idx_a  (instr_idx),
    .rd_data_a (instr_word),
    .rd_idx_b  (data_idx),
    .rd_data_b (data_word)
  );

  assign instr_out = (cpu_run && instr_read) ? instr_word : NOP_INSTR;
  assign data_out  = (cpu_run && data_read)  ? data_word  : '0;

  // Both ports misaligned in one cycle still counts as a single event.
  assign misalign_hit = cpu_run &&
                        ((instr_read && misaligned(instr_addr[1:0])) ||
                         ((data_read || data_write) && misaligned(data_addr[1:0])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= IDLE;
      ready      <= 1'b0;
      load_words <= '0;
    end else begin
      case (mode)
        IDLE: begin
          if (load_en) begin
            mode       <= LOAD;
            ready      <= 1'b0;
            load_words <= '0;
          end else if (start) begin
            mode  <= RUN;
            ready <= 1'b1;
          end
        end
        LOAD: begin
          if (!load_en) begin
            mode  <= RUN;
            ready <= 1'b1;
          end else if (load_we && (load_words != {LOAD_WORDS_W{1'b1}})) begin
            load_words <= load_words + LOAD_WORDS_W'(1);
          end
        end
        RUN: begin
          if (load_en) begin
            mode       <= LOAD;
            ready      <= 1'b0;
            load_words <= '0;
          end
        end
        default: begin
          mode  <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // The error flag is sticky and the counter saturates; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
      err_count    <= '0;
    end else if (misalign_hit) begin
      misalign_err <= 1'b1;
      if (err_count != {ERR_COUNT_W{1'b1}}) begin
        err_count <= err_count + ERR_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed scenarios then random traffic,
// checked against a word-map reference model of the memory slave's rules.
module tb_mem_responder;

  localparam int          AW  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum int {M_IDLE, M_LOAD, M_RUN} model_mode_t;

  typedef struct {
    bit        rst;
    bit        ir;
    bit [31:0] ia;
    bit        dr;
    bit        dw;
    bit [31:0] da;
    bit [31:0] di;
    bit        le;
    bit        lw;
    bit [31:0] la;
    bit [31:0] ld;
    bit        st;
  } stim_t;

  typedef struct {
    string     tag;
    bit [31:0] instr;
    bit        chk_instr;
    bit [31:0] data;
    bit        chk_data;
    bit        ready;
    bit        merr;
    bit [7:0]  ecnt;
    bit [15:0] lwords;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_read = 1'b0;
  logic [31:0] instr_addr = '0;
  logic [31:0] instr_out;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        load_en = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        ready;
  logic        misalign_err;
  logic [7:0]  err_count;
  logic [15:0] load_words;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  bit [31:0]   mdl_mem[int unsigned];
  model_mode_t mdl_mode = M_IDLE;
  bit          mdl_merr = 0;
  int          mdl_ecnt = 0;
  int          mdl_lwords = 0;

  mem_responder #(.ADDR_WIDTH(AW), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_read   (instr_read),
    .instr_addr   (instr_addr),
    .instr_out    (instr_out),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_addr    (data_addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .load_en      (load_en),
    .load_we      (load_we),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .ready        (ready),
    .misalign_err (misalign_err),
    .err_count    (err_count),
    .load_words   (load_words)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int unsigned widx(input bit [31:0] a);
    return (a % (32'd1 << AW)) / 4;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic cmp(input string tag, input string field, input bit [31:0] act, input bit [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.tag, "ready", {31'd0, ready}, {31'd0, e.ready});
    cmp(e.tag, "misalign_err", {31'd0, misalign_err}, {31'd0, e.merr});
    cmp(e.tag, "err_count", {24'd0, err_count}, {24'd0, e.ecnt});
    cmp(e.tag, "load_words", {16'd0, load_words}, {16'd0, e.lwords});
    if (e.chk_instr) cmp(e.tag, "instr_out", instr_out, e.instr);
    if (e.chk_data)  cmp(e.tag, "data_out", data_out, e.data);
  endtask

  // Monitor: compare whatever the driver has queued for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  // Drives one cycle, predicts outputs from the model, then advances the model
  // by the rules that take effect at the coming edge.
  task automatic applyStimulus(input stim_t s, input string tag);
    exp_t e;
    bit   run;
    bit   mis;
    rst = s.rst; instr_read = s.ir; instr_addr = s.ia;
    data_read = s.dr; data_write = s.dw; data_addr = s.da; data_in = s.di;
    load_en = s.le; load_we = s.lw; load_addr = s.la; load_data = s.ld; start = s.st;
    if (s.rst) begin
      mdl_mode = M_IDLE; mdl_merr = 0; mdl_ecnt = 0; mdl_lwords = 0;
    end
    run = (mdl_mode == M_RUN);
    e.tag = tag;
    e.ready = run;
    e.merr = mdl_merr;
    e.ecnt = 8'(mdl_ecnt);
    e.lwords = 16'(mdl_lwords);
    e.instr = NOP; e.chk_instr = 1;
    e.data = 0; e.chk_data = 1;
    if (run && s.ir) begin
      e.chk_instr = mdl_mem.exists(widx(s.ia));
      if (e.chk_instr) e.instr = mdl_mem[widx(s.ia)];
    end
    if (run && s.dr) begin
      e.chk_data = mdl_mem.exists(widx(s.da));
      if (e.chk_data) e.data = mdl_mem[widx(s.da)];
    end
    sb.push_back(e);
    if (!s.rst) begin
      mis = run && ((s.ir && (s.ia % 4 != 0)) || ((s.dr || s.dw) && (s.da % 4 != 0)));
      if (run && s.dw) mdl_mem[widx(s.da)] = s.di;
      if (mdl_mode == M_LOAD && s.le && s.lw) begin
        mdl_mem[widx(s.la)] = s.ld;
        if (mdl_lwords < 65535) mdl_lwords++;
      end
      if (mis) begin
        mdl_merr = 1;
        if (mdl_ecnt < 255) mdl_ecnt++;
      end
      case (mdl_mode)
        M_IDLE: if (s.le) begin mdl_mode = M_LOAD; mdl_lwords = 0; end
                else if (s.st) mdl_mode = M_RUN;
        M_LOAD: if (!s.le) mdl_mode = M_RUN;
        M_RUN:  if (s.le) begin mdl_mode = M_LOAD; mdl_lwords = 0; end
        default: mdl_mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] rand_addr();
    bit [31:0] a;
    a = $urandom_range(0, 63);
    if ($urandom_range(0, 7) == 0) a = a + 32'h0001_0000 * $urandom_range(1, 255);
    return a;
  endfunction

  initial begin
    stim_t s;
    bit    le_hold;
    @(posedge clk);
    #1;

    s = quiet(); s.rst = 1;
    applyStimulus(s, "reset0");
    applyStimulus(s, "reset1");

    // Loader session: IDLE->LOAD wins over start, two words, then release.
    s = quiet(); s.le = 1; s.st = 1;
    applyStimulus(s, "load_enter");
    s = quiet(); s.le = 1; s.lw = 1; s.la = 32'h0; s.ld = 32'h0000_0093;
    applyStimulus(s, "load_w0");
    s.la = 32'h4; s.ld = 32'h0010_0113;
    applyStimulus(s, "load_w1");
    s = quiet();
    applyStimulus(s, "load_exit");
    s = quiet(); s.ir = 1; s.ia = 32'h4;
    applyStimulus(s, "fetch4");
    s.ia = 32'h0;
    applyStimulus(s, "fetch0");

    // Store then load, and same-cycle read-during-write on both ports.
    s = quiet(); s.dw = 1; s.da = 32'h100; s.di = 32'hDEAD_BEEF;
    applyStimulus(s, "st100");
    s = quiet(); s.dr = 1; s.da = 32'h100;
    applyStimulus(s, "ld100");
    s = quiet(); s.dw = 1; s.da = 32'h200; s.di = 32'h1111_1111;
    applyStimulus(s, "st200a");
    s = quiet(); s.dw = 1; s.dr = 1; s.ir = 1; s.ia = 32'h200; s.da = 32'h200; s.di = 32'h2222_2222;
    applyStimulus(s, "rdw200");
    s = quiet(); s.dr = 1; s.ir = 1; s.ia = 32'h200; s.da = 32'h200;
    applyStimulus(s, "after200");
    s = quiet(); s.dw = 1; s.da = 32'h400; s.di = 32'hA5A5_0400;
    applyStimulus(s, "st400");

    // Address wrap: 0x10000 aliases word 0.
    s = quiet(); s.dw = 1; s.da = 32'h0001_0000; s.di = 32'h0BAD_F00D;
    applyStimulus(s, "st_wrap");
    s = quiet(); s.dr = 1; s.da = 32'h0; s.ir = 1; s.ia = 32'h0;
    applyStimulus(s, "rd_wrap");

    // Misaligned load returns the aligned word and drives the error counter to saturation.
    s = quiet(); s.dr = 1; s.da = 32'h102;
    applyStimulus(s, "mis0");
    applyStimulus(s, "mis1");
    s.ir = 1; s.ia = 32'h3;
    for (int i = 0; i < 300; i++) applyStimulus(s, "mis_loop");
    s = quiet();
    applyStimulus(s, "mis_sat");

    // Mid-run reload: the access in the load_en-rise cycle lands, the next is dropped.
    s = quiet(); s.le = 1; s.dw = 1; s.da = 32'h300; s.di = 32'h3000_0001;
    applyStimulus(s, "reload_rise");
    s = quiet(); s.le = 1; s.dw = 1; s.da = 32'h400; s.di = 32'hFFFF_0000;
    s.ir = 1; s.dr = 1; s.ia = 32'h300;
    applyStimulus(s, "reload_drop");
    s = quiet(); s.le = 1; s.lw = 1; s.la = 32'h500; s.ld = 32'h5555_0500;
    applyStimulus(s, "reload_w");
    s = quiet(); s.rst = 1; s.le = 1; s.lw = 1; s.la = 32'h504; s.ld = 32'h5555_0504;
    applyStimulus(s, "reload_rst");

    // IDLE: fetch is NOP and CPU store is dropped; start moves to RUN.
    s = quiet(); s.ir = 1; s.dr = 1; s.dw = 1; s.da = 32'h400; s.di = 32'h1D1E_0000;
    applyStimulus(s, "idle_drop");
    s = quiet(); s.st = 1;
    applyStimulus(s, "start");
    s = quiet(); s.dr = 1; s.da = 32'h400; s.ir = 1; s.ia = 32'h300;
    applyStimulus(s, "run400");
    s.da = 32'h500;
    applyStimulus(s, "run500");

    // Random traffic with persistent loader sessions and rare resets.
    le_hold = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) le_hold = ~le_hold;
      s = quiet();
      s.rst = ($urandom_range(0, 99) == 0);
      s.le = le_hold;
      s.lw = le_hold && ($urandom_range(0, 1) == 1);
      s.la = rand_addr() & 32'hFFFF_FFFC;
      s.ld = $urandom;
      s.st = ($urandom_range(0, 9) == 0);
      s.ir = $urandom_range(0, 1) == 1;
      s.ia = rand_addr();
      s.dr = $urandom_range(0, 1) == 1;
      s.dw = $urandom_range(0, 2) == 0;
      s.da = rand_addr();
      s.di = $urandom;
      applyStimulus(s, "rand");
    end

    s = quiet();
    applyStimulus(s, "tail");
    @(negedge clk);
    #1;
    cmp("end", "scoreboard_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
